// File: rtl/mux_demux_pkg.sv
// Shared widths, types and byte-placement helpers for the mux_8_32 / demux_32_8 datapath pair.
package mux_demux_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned IDX_W          = 2;
   localparam int unsigned PART_W         = BYTE_W * (BYTES_PER_WORD - 1);
   localparam int unsigned CNT_W          = 8;

   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [PART_W-1:0] part_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam idx_t LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
   localparam cnt_t CNT_MAX  = '1;

   // Partial buffer keeps slots 0..2 in the same order they will occupy in the final word.
   function automatic part_t place_byte(input part_t part, input idx_t idx,
                                        input byte_t b, input logic msb_first);
      part_t r;
      r = part;
      case (idx)
         2'd0: begin
            if (msb_first) r[2*BYTE_W +: BYTE_W] = b;
            else           r[0        +: BYTE_W] = b;
         end
         2'd1: r[BYTE_W +: BYTE_W] = b;
         2'd2: begin
            if (msb_first) r[0        +: BYTE_W] = b;
            else           r[2*BYTE_W +: BYTE_W] = b;
         end
         default: r = part;
      endcase
      return r;
   endfunction

   function automatic word_t pack_word(input part_t part, input byte_t last,
                                       input logic msb_first);
      return msb_first ? {part, last} : {last, part};
   endfunction

endpackage

// File: rtl/mux_8_32.sv
// Byte-to-word packer on clk_4f: gathers four valid bytes into a 32-bit word with a one-cycle strobe.
// Optional MUX_8_32_ERR_CNT_EN adds a saturating 8-bit count of discarded fragments on err_cnt.
module mux_8_32 #(
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned BYTES_PER_WORD = 4
) (
   input  logic                  clk_4f,
   input  logic                  reset,
   input  mux_demux_pkg::byte_t  data_in,
   input  logic                  valid_in,
   output mux_demux_pkg::word_t  data_out,
   output logic                  valid_out,
   output logic                  frag_err
`ifdef MUX_8_32_ERR_CNT_EN
   ,output mux_demux_pkg::cnt_t  err_cnt
`endif
);
   import mux_demux_pkg::*;

   localparam bit BPW_OK = (BYTES_PER_WORD == mux_demux_pkg::BYTES_PER_WORD);

   idx_t  idx_q,      idx_d;
   part_t part_q,     part_d;
   word_t data_out_q, data_out_d;
   logic  valid_out_q, valid_out_d;
   logic  frag_err_q,  frag_err_d;

   // Accept, complete, or drop the partial word; strobes default low every cycle.
   always_comb begin
      idx_d       = idx_q;
      part_d      = part_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      frag_err_d  = 1'b0;
      if (valid_in) begin
         if (idx_q == LAST_IDX) begin
            data_out_d  = pack_word(part_q, data_in, MSB_FIRST);
            valid_out_d = 1'b1;
            idx_d       = '0;
            part_d      = '0;
         end else begin
            part_d = place_byte(part_q, idx_q, data_in, MSB_FIRST);
            idx_d  = idx_q + IDX_W'(1);
         end
      end else if (idx_q != '0) begin
         // Any gap mid-word means the upstream word was marked invalid.
         idx_d      = '0;
         part_d     = '0;
         frag_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         idx_q       <= '0;
         part_q      <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         frag_err_q  <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         part_q      <= part_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         frag_err_q  <= frag_err_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign frag_err  = frag_err_q;

`ifdef MUX_8_32_ERR_CNT_EN
   cnt_t err_cnt_q, err_cnt_d;

   // Counts alongside the frag_err pulse; saturates rather than wrapping.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frag_err_d && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_4f) begin
      if (reset) err_cnt_q <= '0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

   a_bpw_fixed: assert property (@(posedge clk_4f) BPW_OK);
   a_valid_single: assert property (@(posedge clk_4f) disable iff (reset)
                                    valid_out_q |=> !valid_out_q);
   a_frag_single: assert property (@(posedge clk_4f) disable iff (reset)
                                   frag_err_q |=> !frag_err_q);
   a_strobe_excl: assert property (@(posedge clk_4f) disable iff (reset)
                                   !(valid_out_q && frag_err_q));

endmodule

// File: tb/tb_mux_8_32.sv
// Bench for mux_8_32: drives an MSB-first and an LSB-first instance from one byte stream.
module tb_mux_8_32;
   import mux_demux_pkg::*;

   logic  clk_4f = 1'b0;
   logic  reset;
   byte_t data_in;
   logic  valid_in;
   word_t data_out_m, data_out_l;
   logic  valid_out_m, valid_out_l;
   logic  frag_err_m, frag_err_l;
`ifdef MUX_8_32_ERR_CNT_EN
   cnt_t  err_cnt_m, err_cnt_l;
`endif

   always #5 clk_4f = ~clk_4f;

   mux_8_32 #(.MSB_FIRST(1'b1)) u_msb (
      .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out_m), .valid_out(valid_out_m), .frag_err(frag_err_m)
`ifdef MUX_8_32_ERR_CNT_EN
      , .err_cnt(err_cnt_m)
`endif
   );

   mux_8_32 #(.MSB_FIRST(1'b0)) u_lsb (
      .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out_l), .valid_out(valid_out_l), .frag_err(frag_err_l)
`ifdef MUX_8_32_ERR_CNT_EN
      , .err_cnt(err_cnt_l)
`endif
   );

   typedef struct {
      byte_t b0, b1, b2, b3;
      word_t exp_msb;
      word_t exp_lsb;
   } vec_t;

   typedef struct {
      word_t m;
      word_t l;
   } exp_t;

   exp_t exp_q[$];
   int   vcyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   frag_seen = 0;
   int   frag_exp = 0;
   int   errc_exp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input logic v, input byte_t b);
      valid_in = v;
      data_in  = b;
      @(posedge clk_4f);
      #1;
   endtask

   task automatic send_word(input vec_t v);
      exp_t e;
      drive(1'b1, v.b0);
      drive(1'b1, v.b1);
      drive(1'b1, v.b2);
      e.m = v.exp_msb;
      e.l = v.exp_lsb;
      exp_q.push_back(e);
      drive(1'b1, v.b3);
   endtask

   task automatic note_frag();
      frag_exp++;
      if (errc_exp < 255) errc_exp++;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_zero(input string name);
      check({name, "_dout_m"}, data_out_m, 32'h0);
      check({name, "_dout_l"}, data_out_l, 32'h0);
      check({name, "_valid"}, {31'h0, valid_out_m | valid_out_l}, 32'h0);
      check({name, "_frag"}, {31'h0, frag_err_m | frag_err_l}, 32'h0);
`ifdef MUX_8_32_ERR_CNT_EN
      check({name, "_errcnt"}, {24'h0, err_cnt_m | err_cnt_l}, 32'h0);
`endif
   endtask

   // Scoreboard: every valid_out strobe must match the oldest pending expected word.
   always @(negedge clk_4f) begin
      exp_t e;
      cyc++;
      if (valid_out_m || valid_out_l) begin
         vcyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h/%h required=none", data_out_m, data_out_l);
         end else begin
            e = exp_q.pop_front();
            check("word_msb", {data_out_m}, e.m);
            check("word_lsb", {data_out_l}, e.l);
            check("valid_pair", {31'h0, valid_out_m & valid_out_l}, 32'h1);
         end
      end
      if (frag_err_m) frag_seen++;
      if (frag_err_m !== frag_err_l) begin
         checks++;
         errors++;
         $display("FAIL frag_pair actual=%b/%b required=equal", frag_err_m, frag_err_l);
      end
   end

   vec_t vecs[5];

   initial begin
      vecs[0] = '{b0:8'hFF, b1:8'hAA, b2:8'hBB, b3:8'h22, exp_msb:32'hFFAABB22, exp_lsb:32'h22BBAAFF};
      vecs[1] = '{b0:8'hFD, b1:8'h55, b2:8'h44, b3:8'h88, exp_msb:32'hFD554488, exp_lsb:32'h884455FD};
      vecs[2] = '{b0:8'hCC, b1:8'hBB, b2:8'hAA, b3:8'hFF, exp_msb:32'hCCBBAAFF, exp_lsb:32'hFFAABBCC};
      vecs[3] = '{b0:8'h11, b1:8'h22, b2:8'h33, b3:8'h44, exp_msb:32'h11223344, exp_lsb:32'h44332211};
      vecs[4] = '{b0:8'hDE, b1:8'hAD, b2:8'hBE, b3:8'hEF, exp_msb:32'hDEADBEEF, exp_lsb:32'hEFBEADDE};

      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      @(posedge clk_4f);
      @(posedge clk_4f);
      #1;
      reset = 1'b0;
      check_zero("reset");

      // Table words sent back to back, no idle cycles in between.
      for (int i = 0; i < 5; i++) send_word(vecs[i]);
      drain("table_drain");
      check("table_count", 32'(vcyc.size()), 32'd5);
      for (int i = 1; i < vcyc.size(); i++) check("b2b_spacing", 32'(vcyc[i] - vcyc[i-1]), 32'd4);
      check("hold_msb", data_out_m, 32'hDEADBEEF);
      check("hold_lsb", data_out_l, 32'hEFBEADDE);

      // Gap mid-word drops the fragment; data_out holds.
      drive(1'b1, 8'h12);
      drive(1'b1, 8'h34);
      note_frag();
      drive(1'b0, 8'hA5);
      check("gap_frag", {31'h0, frag_err_m}, 32'h1);
      check("gap_novalid", {31'h0, valid_out_m}, 32'h0);
      check("gap_hold", data_out_m, 32'hDEADBEEF);
      drive(1'b1, 8'h56);
      check("gap_frag_once", {31'h0, frag_err_m}, 32'h0);
      drive(1'b1, 8'h78);
      drive(1'b1, 8'h9A);
      check("gap_hold2", data_out_l, 32'hEFBEADDE);
      exp_q.push_back('{m:32'h56789ABC, l:32'hBC9A7856});
      drive(1'b1, 8'hBC);
      drain("gap_drain");

      // Reset mid-word: partial lost, no frag_err.
      drive(1'b1, 8'h12);
      drive(1'b1, 8'h34);
      drive(1'b1, 8'h56);
      reset = 1'b1;
      drive(1'b0, 8'h00);
      reset    = 1'b0;
      errc_exp = 0;
      check_zero("midreset");
      drive(1'b1, 8'hDE);
      drive(1'b1, 8'hAD);
      drive(1'b1, 8'hBE);
      exp_q.push_back('{m:32'hDEADBEEF, l:32'hEFBEADDE});
      drive(1'b1, 8'hEF);
      check("midreset_nofrag", {31'h0, frag_err_m}, 32'h0);
      drain("midreset_drain");

      // Single-byte fragments drive the error counter into saturation.
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 8'(k));
         note_frag();
         drive(1'b0, 8'h00);
`ifdef MUX_8_32_ERR_CNT_EN
         if (k == 99) check("errcnt_100", {24'h0, err_cnt_m}, 32'(errc_exp));
`endif
      end
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      check("frag_total", 32'(frag_seen), 32'(frag_exp));
`ifdef MUX_8_32_ERR_CNT_EN
      check("errcnt_sat_m", {24'h0, err_cnt_m}, 32'hFF);
      check("errcnt_sat_l", {24'h0, err_cnt_l}, 32'hFF);
      reset = 1'b1;
      drive(1'b0, 8'h00);
      reset = 1'b0;
      check("errcnt_clr", {24'h0, err_cnt_m}, 32'h0);
`endif
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
